// File: rtl/toe_pkg.sv
// Shared types and constants for the TOE segment transmitter.
// TOE_TX_FCS_EN (optional) appends a CRC-32 FCS after the padded frame.
package toe_pkg;

    localparam int unsigned IP_CSUM_OFS  = 24;
    localparam int unsigned TCP_CSUM_OFS = 50;
    localparam int unsigned HDR_LEN      = 54;
    localparam int unsigned FRAME_LEN    = 60;
    localparam int unsigned FCS_LEN      = 4;
    localparam int unsigned CSUM_WORDS   = 16;
    localparam int unsigned ACC_W        = 20;
    localparam int unsigned BYTE_W       = 6;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP   = 8'h06;

    typedef enum logic [2:0] {IDLE, CSUM, FOLD, SEND, DONE} state_t;

    typedef struct packed {
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] port_src;
        logic [15:0] port_dst;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  tcp_flags;
        logic [15:0] ip_id;
    } conn_t;

    // End-around carry fold of a 20-bit one's-complement accumulator, then invert.
    function automatic logic [15:0] csum_fold(input logic [ACC_W-1:0] acc);
        logic [16:0] s1;
        logic [15:0] s2;
        s1 = 17'(acc[15:0]) + 17'(acc[ACC_W-1:16]);
        s2 = s1[15:0] + 16'(s1[16]);
        return ~s2;
    endfunction

endpackage

// File: rtl/toe_crc32_d8.sv
// One byte step of reflected CRC-32 (poly 0x04C11DB7); built only with TOE_TX_FCS_EN.
`ifdef TOE_TX_FCS_EN
module toe_crc32_d8 (
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_c
);

    always_comb begin
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        crc_c = c;
    end

endmodule
`endif

// File: rtl/toe_seg_tx.sv
// Builds a minimum-size Ethernet/IPv4/TCP segment and streams it byte-wise.
// Define TOE_TX_FCS_EN to append a CRC-32 FCS (bytes 60-63).
module toe_seg_tx
    import toe_pkg::*;
#(
    parameter logic [7:0]  TTL    = 8'd64,
    parameter logic [15:0] WINDOW = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [47:0] mac_src,
    input  logic [47:0] mac_dst,
    input  logic [31:0] ip_src,
    input  logic [31:0] ip_dst,
    input  logic [15:0] port_src,
    input  logic [15:0] port_dst,
    input  logic [31:0] seq_num,
    input  logic [31:0] ack_num,
    input  logic [7:0]  tcp_flags,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop
);

`ifdef TOE_TX_FCS_EN
    localparam int unsigned LAST_BYTE = FRAME_LEN + FCS_LEN - 1;
`else
    localparam int unsigned LAST_BYTE = FRAME_LEN - 1;
`endif
    localparam logic [BYTE_W-1:0] LAST_K = BYTE_W'(LAST_BYTE);

    state_t             state, state_nxt;
    conn_t              conn, conn_nxt;
    logic [3:0]         idx, idx_nxt;
    logic [BYTE_W-1:0]  k, k_nxt, k_load_c;
    logic [ACC_W-1:0]   ip_acc, ip_acc_nxt, tcp_acc, tcp_acc_nxt;
    logic [15:0]        ip_csum, ip_csum_nxt, tcp_csum, tcp_csum_nxt;
    logic [15:0]        ip_id, ip_id_nxt;
    logic               busy_nxt, done_nxt, tx_valid_nxt, tx_sop_nxt, tx_eop_nxt;
    logic [7:0]         tx_data_nxt, byte_c;

    function automatic logic [15:0] ip_word(input conn_t c, input logic [3:0] i);
        case (i)
            4'd0:    return 16'h4500;
            4'd1:    return 16'h0028;
            4'd2:    return c.ip_id;
            4'd3:    return 16'h4000;
            4'd4:    return {TTL, IP_PROTO_TCP};
            4'd6:    return c.ip_src[31:16];
            4'd7:    return c.ip_src[15:0];
            4'd8:    return c.ip_dst[31:16];
            4'd9:    return c.ip_dst[15:0];
            default: return 16'h0000;
        endcase
    endfunction

    // Pseudo header (6 words) followed by the TCP header with checksum zeroed.
    function automatic logic [15:0] tcp_word(input conn_t c, input logic [3:0] i);
        case (i)
            4'd0:    return c.ip_src[31:16];
            4'd1:    return c.ip_src[15:0];
            4'd2:    return c.ip_dst[31:16];
            4'd3:    return c.ip_dst[15:0];
            4'd4:    return {8'h00, IP_PROTO_TCP};
            4'd5:    return 16'h0014;
            4'd6:    return c.port_src;
            4'd7:    return c.port_dst;
            4'd8:    return c.seq_num[31:16];
            4'd9:    return c.seq_num[15:0];
            4'd10:   return c.ack_num[31:16];
            4'd11:   return c.ack_num[15:0];
            4'd12:   return {8'h50, c.tcp_flags};
            4'd13:   return WINDOW;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input conn_t c, input logic [BYTE_W-1:0] kk,
                                              input logic [15:0] ipcs, input logic [15:0] tcpcs);
        logic [HDR_LEN*8-1:0] h;
        logic [8:0]           sh;
        logic [7:0]           b;
        h = {c.mac_dst, c.mac_src, ETHERTYPE_IPV4, 8'h45, 8'h00, 16'h0028, c.ip_id,
             16'h4000, TTL, IP_PROTO_TCP, 16'h0000, c.ip_src, c.ip_dst,
             c.port_src, c.port_dst, c.seq_num, c.ack_num, 8'h50, c.tcp_flags,
             WINDOW, 16'h0000, 16'h0000};
        b = 8'h00;
        if (32'(kk) < HDR_LEN) begin
            sh = 9'(8 * (HDR_LEN - 1 - 32'(kk)));
            b  = h[sh +: 8];
        end
        if (32'(kk) == IP_CSUM_OFS)      b = ipcs[15:8];
        if (32'(kk) == IP_CSUM_OFS + 1)  b = ipcs[7:0];
        if (32'(kk) == TCP_CSUM_OFS)     b = tcpcs[15:8];
        if (32'(kk) == TCP_CSUM_OFS + 1) b = tcpcs[7:0];
        return b;
    endfunction

`ifdef TOE_TX_FCS_EN
    logic [31:0] crc, crc_nxt, crc_step_c, fcs_c;

    toe_crc32_d8 u_crc (
        .crc   (crc),
        .data  (tx_data),
        .crc_c (crc_step_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc <= 32'hFFFF_FFFF;
        else        crc <= crc_nxt;
    end
`endif

    // Next byte to present: byte 0 on entry to SEND, otherwise k+1.
    always_comb begin
        k_load_c = tx_valid ? BYTE_W'(k + 1'b1) : '0;
        byte_c   = frame_byte(conn, k_load_c, ip_csum, tcp_csum);
`ifdef TOE_TX_FCS_EN
        // Byte 59 is still being accepted when byte 60 loads, so use the stepped CRC.
        fcs_c = (32'(k_load_c) == FRAME_LEN) ? ~crc_step_c : ~crc;
        if (32'(k_load_c) >= FRAME_LEN) begin
            case (k_load_c[1:0])
                2'd0:    byte_c = fcs_c[7:0];
                2'd1:    byte_c = fcs_c[15:8];
                2'd2:    byte_c = fcs_c[23:16];
                default: byte_c = fcs_c[31:24];
            endcase
        end
`endif
    end

    always_comb begin
        state_nxt    = state;
        conn_nxt     = conn;
        idx_nxt      = idx;
        k_nxt        = k;
        ip_acc_nxt   = ip_acc;
        tcp_acc_nxt  = tcp_acc;
        ip_csum_nxt  = ip_csum;
        tcp_csum_nxt = tcp_csum;
        ip_id_nxt    = ip_id;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        tx_valid_nxt = tx_valid;
        tx_data_nxt  = tx_data;
        tx_sop_nxt   = tx_sop;
        tx_eop_nxt   = tx_eop;
`ifdef TOE_TX_FCS_EN
        crc_nxt      = crc;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    conn_nxt.mac_dst   = mac_dst;
                    conn_nxt.mac_src   = mac_src;
                    conn_nxt.ip_src    = ip_src;
                    conn_nxt.ip_dst    = ip_dst;
                    conn_nxt.port_src  = port_src;
                    conn_nxt.port_dst  = port_dst;
                    conn_nxt.seq_num   = seq_num;
                    conn_nxt.ack_num   = ack_num;
                    conn_nxt.tcp_flags = tcp_flags;
                    conn_nxt.ip_id     = ip_id;
                    idx_nxt     = '0;
                    ip_acc_nxt  = '0;
                    tcp_acc_nxt = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = CSUM;
`ifdef TOE_TX_FCS_EN
                    crc_nxt     = 32'hFFFF_FFFF;
`endif
                end
            end
            CSUM: begin
                ip_acc_nxt  = ip_acc + ACC_W'(ip_word(conn, idx));
                tcp_acc_nxt = tcp_acc + ACC_W'(tcp_word(conn, idx));
                idx_nxt     = idx + 4'd1;
                if (32'(idx) == CSUM_WORDS - 1) state_nxt = FOLD;
            end
            FOLD: begin
                ip_csum_nxt  = csum_fold(ip_acc);
                tcp_csum_nxt = csum_fold(tcp_acc);
                k_nxt        = '0;
                state_nxt    = SEND;
            end
            SEND: begin
                if (!tx_valid) begin
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = byte_c;
                    tx_sop_nxt   = 1'b1;
                    tx_eop_nxt   = 1'b0;
                end else if (tx_ready) begin
`ifdef TOE_TX_FCS_EN
                    if (32'(k) < FRAME_LEN) crc_nxt = crc_step_c;
`endif
                    if (k == LAST_K) begin
                        tx_valid_nxt = 1'b0;
                        tx_data_nxt  = 8'h00;
                        tx_sop_nxt   = 1'b0;
                        tx_eop_nxt   = 1'b0;
                        done_nxt     = 1'b1;
                        state_nxt    = DONE;
                    end else begin
                        k_nxt       = k_load_c;
                        tx_data_nxt = byte_c;
                        tx_sop_nxt  = 1'b0;
                        tx_eop_nxt  = (k_load_c == LAST_K);
                    end
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                ip_id_nxt = ip_id + 16'd1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            conn     <= '0;
            idx      <= '0;
            k        <= '0;
            ip_acc   <= '0;
            tcp_acc  <= '0;
            ip_csum  <= '0;
            tcp_csum <= '0;
            ip_id    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
        end else begin
            state    <= state_nxt;
            conn     <= conn_nxt;
            idx      <= idx_nxt;
            k        <= k_nxt;
            ip_acc   <= ip_acc_nxt;
            tcp_acc  <= tcp_acc_nxt;
            ip_csum  <= ip_csum_nxt;
            tcp_csum <= tcp_csum_nxt;
            ip_id    <= ip_id_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            tx_valid <= tx_valid_nxt;
            tx_data  <= tx_data_nxt;
            tx_sop   <= tx_sop_nxt;
            tx_eop   <= tx_eop_nxt;
        end
    end

endmodule

// File: tb/tb_toe_seg_tx.sv
// Directed bench for toe_seg_tx; frame bytes checked against a byte-level reference model.
module tb_toe_seg_tx;

`ifdef TOE_TX_FCS_EN
    localparam int LAST = 63;
`else
    localparam int LAST = 59;
`endif

    logic        clk, rst_n, start, busy, done, tx_valid, tx_ready, tx_sop, tx_eop;
    logic [47:0] mac_src, mac_dst;
    logic [31:0] ip_src, ip_dst, seq_num, ack_num;
    logic [15:0] port_src, port_dst;
    logic [7:0]  tcp_flags, tx_data;

    toe_seg_tx dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mac_src(mac_src), .mac_dst(mac_dst), .ip_src(ip_src), .ip_dst(ip_dst),
        .port_src(port_src), .port_dst(port_dst), .seq_num(seq_num), .ack_num(ack_num),
        .tcp_flags(tcp_flags), .busy(busy), .done(done), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop), .tx_eop(tx_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got  [0:63];
    logic [7:0] expb [0:63];
    int n_got, lat, sop_bad, eop_bad, hold_bad, gap_bad, done_cyc, last_cyc;
    logic busy_after;
    bit   done_seen;

    task automatic put(input int ofs, input int n, input logic [63:0] v);
        logic [63:0] t;
        for (int i = 0; i < n; i++) begin
            t = v >> (8 * (n - 1 - i));
            expb[ofs + i] = t[7:0];
        end
    endtask

    task automatic build_exp(input logic [15:0] id);
        int unsigned s;
        logic [15:0] cs;
        logic [31:0] c;
        for (int i = 0; i < 64; i++) expb[i] = 8'h00;
        put(0, 6, 64'(mac_dst));   put(6, 6, 64'(mac_src));   put(12, 2, 64'h0800);
        expb[14] = 8'h45;          expb[15] = 8'h00;          put(16, 2, 64'h0028);
        put(18, 2, 64'(id));       put(20, 2, 64'h4000);
        expb[22] = 8'd64;          expb[23] = 8'h06;
        put(26, 4, 64'(ip_src));   put(30, 4, 64'(ip_dst));
        put(34, 2, 64'(port_src)); put(36, 2, 64'(port_dst));
        put(38, 4, 64'(seq_num));  put(42, 4, 64'(ack_num));
        expb[46] = 8'h50;          expb[47] = tcp_flags;      put(48, 2, 64'hFFFF);
        s = 0;
        for (int i = 14; i < 34; i += 2) s += {16'h0, expb[i], expb[i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        expb[24] = cs[15:8]; expb[25] = cs[7:0];
        s = 32'h6 + 32'd20;
        for (int i = 26; i < 34; i += 2) s += {16'h0, expb[i], expb[i+1]};
        for (int i = 34; i < 54; i += 2) s += {16'h0, expb[i], expb[i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        expb[50] = cs[15:8]; expb[51] = cs[7:0];
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            c = c ^ {24'h0, expb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        expb[60] = c[7:0]; expb[61] = c[15:8]; expb[62] = c[23:16]; expb[63] = c[31:24];
    endtask

    // Pulse start, then record the frame until done (or budget expiry).
    task automatic capture(input bit rnd, input int poke_cyc, input bit poke_done);
        bit         pend, r;
        logic [7:0] pd;
        logic       ps, pe;
        n_got = 0; lat = -1; sop_bad = 0; eop_bad = 0; hold_bad = 0; gap_bad = 0;
        done_seen = 0; done_cyc = -1; last_cyc = -1; busy_after = 1'bx; pend = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (pend && (!tx_valid || tx_data !== pd || tx_sop !== ps || tx_eop !== pe)) hold_bad++;
            pend = 0;
            if (tx_valid && lat < 0) lat = cyc;
            if (!tx_valid && lat >= 0 && !done) gap_bad++;
            if (done) begin
                done_seen = 1; done_cyc = cyc;
                start = poke_done;
                @(negedge clk);
                start = 1'b0;
                busy_after = busy;
                break;
            end
            start = (cyc == poke_cyc);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_ready = r;
            if (tx_valid) begin
                if (r) begin
                    if (n_got < 64) got[n_got] = tx_data;
                    if (tx_sop !== (n_got == 0)) sop_bad++;
                    if (tx_eop !== (n_got == LAST)) eop_bad++;
                    n_got++;
                    last_cyc = cyc;
                end else begin
                    pend = 1; pd = tx_data; ps = tx_sop; pe = tx_eop;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic set_fields_a();
        mac_dst = 48'h0A0B0C0D0E0F; mac_src = 48'h020406080A0C;
        ip_src = 32'h11111111; ip_dst = 32'h22222222;
        port_src = 16'h5555; port_dst = 16'h6666;
        seq_num = 32'h0; ack_num = 32'h0; tcp_flags = 8'h02;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
        set_fields_a();
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", tx_valid); end
        n_checks++; if (tx_sop !== 1'b0)   begin n_fail++; $display("FAIL reset_sop got %b want 0", tx_sop); end
        n_checks++; if (tx_eop !== 1'b0)   begin n_fail++; $display("FAIL reset_eop got %b want 0", tx_eop); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", tx_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame(input string name);
        int mm, first;
        mm = 0; first = -1;
        for (int i = 0; i <= LAST; i++) if (got[i] !== expb[i]) begin mm++; if (first < 0) first = i; end
        n_checks++;
        if (mm != 0) begin
            n_fail++;
            $display("FAIL %s_bytes %0d wrong bytes, first at %0d got %h want %h",
                     name, mm, first, got[first], expb[first]);
        end
    endtask

    task automatic test_first_frame();
        set_fields_a();
        build_exp(16'd0);
        capture(1'b0, -1, 1'b0);
        n_checks++; if (!done_seen)        begin n_fail++; $display("FAIL f1_done_timeout got %0d bytes", n_got); end
        n_checks++; if (got[24] !== 8'hD4) begin n_fail++; $display("FAIL f1_ipcs_hi got %h want d4", got[24]); end
        n_checks++; if (got[25] !== 8'h6A) begin n_fail++; $display("FAIL f1_ipcs_lo got %h want 6a", got[25]); end
        n_checks++; if (got[47] !== 8'h02) begin n_fail++; $display("FAIL f1_flags got %h want 02", got[47]); end
        n_checks++; if ({got[50], got[51]} !== {expb[50], expb[51]})
            begin n_fail++; $display("FAIL f1_tcpcs got %h%h want %h%h", got[50], got[51], expb[50], expb[51]); end
        n_checks++; if ({got[18], got[19]} !== 16'h0000)
            begin n_fail++; $display("FAIL f1_ipid got %h%h want 0000", got[18], got[19]); end
        check_frame("f1");
    endtask

    task automatic test_timing();
        build_exp(16'd1);
        capture(1'b0, -1, 1'b0);
        n_checks++; if (lat != 18)          begin n_fail++; $display("FAIL lat got %0d want 18", lat); end
        n_checks++; if (n_got != LAST + 1)  begin n_fail++; $display("FAIL beats got %0d want %0d", n_got, LAST + 1); end
        n_checks++; if (last_cyc != 18 + LAST) begin n_fail++; $display("FAIL last_beat_cyc got %0d want %0d", last_cyc, 18 + LAST); end
        n_checks++; if (gap_bad != 0)       begin n_fail++; $display("FAIL valid_gap got %0d want 0", gap_bad); end
        n_checks++; if (sop_bad != 0)       begin n_fail++; $display("FAIL sop got %0d bad want 0", sop_bad); end
        n_checks++; if (eop_bad != 0)       begin n_fail++; $display("FAIL eop got %0d bad want 0", eop_bad); end
        n_checks++; if (done_cyc != last_cyc + 1) begin n_fail++; $display("FAIL done_cyc got %0d want %0d", done_cyc, last_cyc + 1); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL busy_after_done got %b want 0", busy_after); end
        n_checks++; if ({got[18], got[19]} !== 16'h0001)
            begin n_fail++; $display("FAIL f2_ipid got %h%h want 0001", got[18], got[19]); end
        check_frame("f2");
    endtask

    task automatic test_back_pressure();
        build_exp(16'd2);
        capture(1'b1, -1, 1'b0);
        n_checks++; if (!done_seen)         begin n_fail++; $display("FAIL bp_done_timeout got %0d bytes", n_got); end
        n_checks++; if (n_got != LAST + 1)  begin n_fail++; $display("FAIL bp_beats got %0d want %0d", n_got, LAST + 1); end
        n_checks++; if (hold_bad != 0)      begin n_fail++; $display("FAIL bp_hold got %0d unstable want 0", hold_bad); end
        n_checks++; if (sop_bad + eop_bad != 0) begin n_fail++; $display("FAIL bp_sop_eop got %0d bad want 0", sop_bad + eop_bad); end
        check_frame("bp");
    endtask

    task automatic test_busy_start();
        int extra;
        tcp_flags = 8'h12; seq_num = 32'h01020304; ack_num = 32'hA0B0C0D0; port_src = 16'hC001;
        build_exp(16'd3);
        capture(1'b0, 40, 1'b1);
        n_checks++; if (n_got != LAST + 1) begin n_fail++; $display("FAIL bs_beats got %0d want %0d", n_got, LAST + 1); end
        check_frame("bs");
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_valid || busy) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL bs_extra_frame got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_abort();
        int  acc;
        bit  hit;
        acc = 0; hit = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; tx_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (tx_valid) begin
                if (acc == 30) begin
                    rst_n = 1'b0;
                    #1;
                    hit = 1;
                    break;
                end
                acc++;
            end
            @(negedge clk);
        end
        n_checks++; if (!hit)              begin n_fail++; $display("FAIL abort_reach got %0d bytes want 30", acc); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", tx_valid); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        @(negedge clk); rst_n = 1'b1;
        set_fields_a();
        build_exp(16'd0);
        capture(1'b0, -1, 1'b0);
        n_checks++; if (lat != 18)     begin n_fail++; $display("FAIL post_abort_lat got %0d want 18", lat); end
        n_checks++; if (sop_bad != 0)  begin n_fail++; $display("FAIL post_abort_sop got %0d bad want 0", sop_bad); end
        n_checks++; if ({got[18], got[19]} !== 16'h0000)
            begin n_fail++; $display("FAIL post_abort_ipid got %h%h want 0000", got[18], got[19]); end
        check_frame("pa");
    endtask

`ifdef TOE_TX_FCS_EN
    task automatic test_fcs();
        set_fields_a();
        build_exp(16'd1);
        capture(1'b1, -1, 1'b0);
        n_checks++;
        if ({got[63], got[62], got[61], got[60]} !== {expb[63], expb[62], expb[61], expb[60]}) begin
            n_fail++;
            $display("FAIL fcs got %h%h%h%h want %h%h%h%h", got[63], got[62], got[61], got[60],
                     expb[63], expb[62], expb[61], expb[60]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_timing();
        test_back_pressure();
        test_busy_start();
        test_reset_abort();
`ifdef TOE_TX_FCS_EN
        test_fcs();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
